packet_buffer_reader: RTL and testbench

//  Drains packets from the read side of the packet buffer and streams each one out as an
//  AXI4-Stream beat sequence. The buffer is filled by the RX MAC; this block feeds the

---
 rtl/eth_pkt_pkg.sv | 33 +++
 rtl/pkt_skid_buf_2.sv | 50 +++++
 rtl/packet_buffer_reader.sv | 137 +++++++++++++
 tb/tb_packet_buffer_reader.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkt_pkg.sv
// Shared types and helpers for the packet buffer read path.
// Beat fields are sized for the widest supported word; narrower configs use the low bits.
package eth_pkt_pkg;

    localparam int unsigned MaxDataWidth = 64;
    localparam int unsigned MaxBpw       = MaxDataWidth / 8;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        ACK
    } reader_state_e;

    typedef struct packed {
        logic [MaxDataWidth-1:0] data;
        logic [MaxBpw-1:0]       keep;
        logic                    last;
    } stream_beat_t;

    // Byte enables for a beat holding rem valid bytes; rem==0 means a full word.
    function automatic logic [MaxBpw-1:0] keep_from_rem(input int unsigned rem,
                                                        input int unsigned bpw);
        logic [MaxBpw-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < MaxBpw; i++) begin
            if ((i < bpw) && ((rem == 0) || (i < rem))) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/pkt_skid_buf_2.sv
// Two-entry FIFO of stream beats that absorbs the buffer's one-cycle read latency.
// The head entry is driven straight from registers so the stream outputs are glitch-free.
module pkt_skid_buf_2
    import eth_pkt_pkg::*;
(
    input  logic         clk_i,
    input  logic         reset_n_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  stream_beat_t in_beat_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output stream_beat_t out_beat_o,
    output logic [1:0]   count_o
);

    stream_beat_t r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign in_ready_o  = (r_count != 2'd2);
    assign out_valid_o = (r_count != 2'd0);
    assign out_beat_o  = r_mem[r_rd_ptr];
    assign count_o     = r_count;
    assign w_push      = in_valid_i && in_ready_o;
    assign w_pop       = out_valid_o && out_ready_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_beat_i;
                r_wr_ptr        <= !r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= !r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: rtl/packet_buffer_reader.sv
// Streams each packet in the buffer read slot out as AXI4-Stream beats, then frees the
// slot with a one-cycle ack once the last beat has been accepted.
module packet_buffer_reader
    import eth_pkt_pkg::*;
#(
    parameter  int unsigned data_width_p  = 64,
    parameter  int unsigned els_p         = 2048,
    localparam int unsigned bpw_lp        = data_width_p / 8,
    localparam int unsigned addr_width_lp = $clog2(els_p),
    localparam int unsigned size_width_lp = $clog2(els_p + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     packet_avail_i,
    output logic                     packet_ack_o,
    output logic                     packet_rvalid_o,
    output logic [addr_width_lp-1:0] packet_raddr_o,
    input  logic [data_width_p-1:0]  packet_rdata_i,
    input  logic [size_width_lp-1:0] packet_rsize_i,
    output logic                     m_tvalid_o,
    input  logic                     m_tready_i,
    output logic [data_width_p-1:0]  m_tdata_o,
    output logic [bpw_lp-1:0]        m_tkeep_o,
    output logic                     m_tlast_o,
    output logic                     busy_o
);

    localparam int unsigned shift_lp     = $clog2(bpw_lp);
    localparam int unsigned idx_width_lp = size_width_lp + 1;

    reader_state_e           r_state;
    reader_state_e           w_state_next;
    logic [idx_width_lp-1:0] r_nwords;
    logic [idx_width_lp-1:0] r_rd_idx;
    logic [shift_lp-1:0]     r_size_rem;
    logic                    r_inflight;
    logic                    r_inflight_last;

    logic [idx_width_lp-1:0] w_nwords;
    logic                    w_issue;
    logic                    w_issue_last;
    logic                    w_pop;
    logic                    w_credit_ok;
    logic [31:0]             w_keep_rem;
    logic [1:0]              w_skid_count;
    logic                    w_skid_in_ready;
    logic                    w_skid_out_valid;
    stream_beat_t            w_skid_in;
    stream_beat_t            w_skid_out;

    assign w_nwords = ({1'b0, packet_rsize_i} + idx_width_lp'(bpw_lp - 1)) >> shift_lp;

    // A read may issue only if its data is guaranteed a skid slot when it returns.
    assign w_pop        = w_skid_out_valid && m_tready_i;
    assign w_credit_ok  = ({1'b0, w_skid_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
    assign w_issue      = (r_state == STREAM) && (r_rd_idx < r_nwords) && w_credit_ok;
    assign w_issue_last = (r_rd_idx == (r_nwords - idx_width_lp'(1)));

    assign w_keep_rem = r_inflight_last ? 32'(r_size_rem) : 32'd0;

    always_comb begin
        w_skid_in      = '0;
        w_skid_in.data = MaxDataWidth'(packet_rdata_i);
        w_skid_in.keep = keep_from_rem(w_keep_rem, bpw_lp);
        w_skid_in.last = r_inflight_last;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (packet_avail_i) begin
                    w_state_next = (packet_rsize_i == '0) ? ACK : STREAM;
                end
            end
            STREAM: begin
                if (w_pop && w_skid_out.last) begin
                    w_state_next = ACK;
                end
            end
            ACK:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state         <= IDLE;
            r_nwords        <= '0;
            r_rd_idx        <= '0;
            r_size_rem      <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && w_issue_last;
            if ((r_state == IDLE) && packet_avail_i) begin
                r_nwords   <= w_nwords;
                r_size_rem <= packet_rsize_i[shift_lp-1:0];
                r_rd_idx   <= '0;
            end else if (w_issue) begin
                r_rd_idx <= r_rd_idx + idx_width_lp'(1);
            end
        end
    end

    pkt_skid_buf_2 u_skid (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .in_valid_i  (r_inflight),
        .in_ready_o  (w_skid_in_ready),
        .in_beat_i   (w_skid_in),
        .out_valid_o (w_skid_out_valid),
        .out_ready_i (m_tready_i),
        .out_beat_o  (w_skid_out),
        .count_o     (w_skid_count)
    );

    assign packet_ack_o    = (r_state == ACK);
    assign busy_o          = (r_state != IDLE);
    assign packet_rvalid_o = w_issue;
    assign packet_raddr_o  = {r_rd_idx[addr_width_lp-shift_lp-1:0], {shift_lp{1'b0}}};
    assign m_tvalid_o      = w_skid_out_valid;
    assign m_tdata_o       = w_skid_out.data[data_width_p-1:0];
    assign m_tkeep_o       = w_skid_out.keep[bpw_lp-1:0];
    assign m_tlast_o       = w_skid_out.last;

    // The slot must stay owned for the whole packet and never report an oversize length.
    a_avail_held: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (r_state == STREAM) |-> packet_avail_i);
    a_size_range: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        ((r_state == IDLE) && packet_avail_i) |-> (packet_rsize_i <= size_width_lp'(els_p)));
    a_skid_room: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        r_inflight |-> w_skid_in_ready);

endmodule

// File: tb/tb_packet_buffer_reader.sv
// Scoreboard bench: stimulus queues expected beats/addresses/acks, negedge monitors compare.
// A behavioural buffer model answers reads one cycle later and retires a packet on ack.
module tb_packet_buffer_reader;

    typedef struct {
        int pid;
        int size;
    } pkt_t;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        avail = 1'b0;
    logic [11:0] rsize = '0;
    logic [63:0] rdata = '0;
    logic        tready = 1'b1;
    logic        ack, rvalid, tvalid, tlast, busy;
    logic [10:0] raddr;
    logic [63:0] tdata;
    logic [7:0]  tkeep;

    logic        avail32 = 1'b0;
    logic [11:0] rsize32 = '0;
    logic [31:0] rdata32 = '0;
    logic        tready32 = 1'b1;
    logic        ack32, rvalid32, tvalid32, tlast32, busy32;
    logic [10:0] raddr32;
    logic [31:0] tdata32;
    logic [3:0]  tkeep32;

    int n_checks = 0, n_fail = 0;
    int n_ack = 0, exp_ack = 0, n_ack32 = 0;
    int cyc = 0, rd_out = 0, hs_cnt = 0, last_hs_cyc = 0, last_gap = -1;
    int lat_c0 = 0, last_lat = -1;
    bit gap_armed = 0, rnd_ready = 0, prev_stall = 0, prev_last_hs = 0;
    bit prev_ack = 0, prev_tvalid = 0;
    logic [63:0] prev_data;
    logic [7:0]  prev_keep;
    logic        prev_last;
    logic        ack_s = 1'b0, rd_s = 1'b0, ack32_s = 1'b0, rd32_s = 1'b0;
    logic [10:0] raddr_s = '0, raddr32_s = '0;
    logic [63:0] w64_env;
    beat_t       e_mon, e_mon32;
    pkt_t        pkt_q[$], pkt32_q[$];
    beat_t       exp_q[$], exp32_q[$];
    int          exp_raddr[$], exp_raddr32[$];

    packet_buffer_reader #(.data_width_p(64), .els_p(2048)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .packet_avail_i(avail), .packet_ack_o(ack),
        .packet_rvalid_o(rvalid), .packet_raddr_o(raddr), .packet_rdata_i(rdata),
        .packet_rsize_i(rsize), .m_tvalid_o(tvalid), .m_tready_i(tready), .m_tdata_o(tdata),
        .m_tkeep_o(tkeep), .m_tlast_o(tlast), .busy_o(busy)
    );

    packet_buffer_reader #(.data_width_p(32), .els_p(2048)) dut32 (
        .clk_i(clk), .reset_n_i(rst_n), .packet_avail_i(avail32), .packet_ack_o(ack32),
        .packet_rvalid_o(rvalid32), .packet_raddr_o(raddr32), .packet_rdata_i(rdata32),
        .packet_rsize_i(rsize32), .m_tvalid_o(tvalid32), .m_tready_i(tready32),
        .m_tdata_o(tdata32), .m_tkeep_o(tkeep32), .m_tlast_o(tlast32), .busy_o(busy32)
    );

    function automatic logic [7:0] byte_at(input int pid, input int addr);
        return 8'((pid * 29 + addr * 7 + 3) & 255);
    endfunction

    function automatic logic [63:0] word_at(input int pid, input int addr, input int bpw);
        logic [63:0] w;
        w = '0;
        for (int b = 0; b < bpw; b++) w[8*b +: 8] = byte_at(pid, addr + b);
        return w;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_pkt(input int pid, input int size, input logic [7:0] last_keep);
        int    n;
        beat_t b;
        n = (size + 7) / 8;
        for (int i = 0; i < n; i++) begin
            b.data = word_at(pid, 8 * i, 8);
            b.keep = (i == n - 1) ? last_keep : 8'hFF;
            b.last = (i == n - 1);
            exp_q.push_back(b);
            exp_raddr.push_back(8 * i);
        end
    endtask

    task automatic add_pkt(input int pid, input int size, input logic [7:0] last_keep);
        pkt_t p;
        expect_pkt(pid, size, last_keep);
        p.pid  = pid;
        p.size = size;
        pkt_q.push_back(p);
        exp_ack++;
    endtask

    task automatic wait_acks(input int target, input int budget);
        int t;
        t = 0;
        while (n_ack < target && t < budget) begin
            @(posedge clk);
            t++;
        end
        repeat (4) @(posedge clk);
        check("ack_count", n_ack, target);
        check("beats_left", exp_q.size(), 0);
    endtask

    // Buffer model: answers reads, retires packets on ack, drives tready.
    always @(posedge clk) begin
        #1;
        if (ack_s && pkt_q.size() > 0) void'(pkt_q.pop_front());
        rdata = '0;
        if (rd_s && pkt_q.size() > 0) rdata = word_at(pkt_q[0].pid, int'(raddr_s), 8);
        avail = (pkt_q.size() > 0);
        rsize = '0;
        if (avail) rsize = 12'(pkt_q[0].size);
        tready = rnd_ready ? ($urandom_range(0, 99) < 40) : 1'b1;

        if (ack32_s && pkt32_q.size() > 0) void'(pkt32_q.pop_front());
        rdata32 = '0;
        if (rd32_s && pkt32_q.size() > 0) begin
            w64_env = word_at(pkt32_q[0].pid, int'(raddr32_s), 4);
            rdata32 = w64_env[31:0];
        end
        avail32 = (pkt32_q.size() > 0);
        rsize32 = '0;
        if (avail32) rsize32 = 12'(pkt32_q[0].size);
    end

    always @(negedge clk) begin
        ack_s   = ack;
        rd_s    = rvalid;
        raddr_s = raddr;
        if (!rst_n) begin
            rd_out       = 0;
            prev_stall   = 0;
            prev_last_hs = 0;
            prev_ack     = 0;
            prev_tvalid  = 0;
            gap_armed    = 0;
        end else begin
            cyc++;
            if (avail && !busy) lat_c0 = cyc;
            if (tvalid && !prev_tvalid) last_lat = cyc - lat_c0;
            if (rvalid) begin
                rd_out++;
                if (gap_armed) begin
                    last_gap  = cyc - last_hs_cyc - 1;
                    gap_armed = 0;
                end
                if (exp_raddr.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL raddr: unexpected read at 0x%0h", raddr);
                end else begin
                    check("raddr", 64'(raddr), 64'(exp_raddr.pop_front()));
                end
            end
            if (prev_stall) begin
                check("stall_tvalid", tvalid, 1);
                check("stall_tdata", tdata, prev_data);
                check("stall_tkeep_tlast", {tkeep, tlast}, {prev_keep, prev_last});
            end
            if (prev_last_hs) check("ack_after_last", ack, 1);
            if (ack) begin
                n_ack++;
                check("ack_single_cycle", prev_ack, 0);
            end
            prev_last_hs = 0;
            if (tvalid && tready) begin
                hs_cnt++;
                rd_out--;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL beat: unexpected beat data 0x%0h", tdata);
                end else begin
                    e_mon = exp_q.pop_front();
                    check("tdata", tdata, e_mon.data);
                    check("tkeep", tkeep, e_mon.keep);
                    check("tlast", tlast, e_mon.last);
                end
                if (tlast) begin
                    prev_last_hs = 1;
                    last_hs_cyc  = cyc;
                    gap_armed    = 1;
                end
            end
            if (rvalid) check("outstanding_le_2", rd_out <= 2, 1);
            prev_stall  = tvalid && !tready;
            prev_data   = tdata;
            prev_keep   = tkeep;
            prev_last   = tlast;
            prev_ack    = ack;
            prev_tvalid = tvalid;
        end
    end

    always @(negedge clk) begin
        ack32_s   = ack32;
        rd32_s    = rvalid32;
        raddr32_s = raddr32;
        if (rst_n) begin
            if (rvalid32) begin
                if (exp_raddr32.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL raddr32: unexpected read at 0x%0h", raddr32);
                end else begin
                    check("raddr32", 64'(raddr32), 64'(exp_raddr32.pop_front()));
                end
            end
            if (tvalid32 && tready32) begin
                if (exp32_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL beat32: unexpected beat data 0x%0h", tdata32);
                end else begin
                    e_mon32 = exp32_q.pop_front();
                    check("tdata32", 64'(tdata32), e_mon32.data);
                    check("tkeep32", 64'(tkeep32), e_mon32.keep);
                    check("tlast32", tlast32, e_mon32.last);
                end
            end
            if (ack32) n_ack32++;
        end
    end

    initial begin
        int    base;
        int    t;
        pkt_t  p;
        beat_t b;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", tvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_tdata", tdata, 0);
        check("rst_tkeep_tlast", {tkeep, tlast}, 0);
        check("rst_raddr", 64'(raddr), 0);
        check("rst_tvalid32", tvalid32, 0);
        @(negedge clk);
        rst_n = 1'b1;

        add_pkt(1, 13, 8'h1F);
        wait_acks(exp_ack, 100);
        check("first_beat_latency", last_lat, 3);

        add_pkt(2, 8, 8'hFF);
        add_pkt(3, 0, 8'hFF);
        wait_acks(exp_ack, 100);

        rnd_ready = 1;
        add_pkt(4, 64, 8'hFF);
        wait_acks(exp_ack, 400);
        rnd_ready = 0;

        add_pkt(6, 24, 8'hFF);
        add_pkt(7, 17, 8'h01);
        wait_acks(exp_ack, 200);
        check("pkt_gap", last_gap, 2);

        // Abort while beat 3 of 8 is on the stream; the packet must restream from word 0.
        add_pkt(8, 64, 8'hFF);
        base = hs_cnt;
        t    = 0;
        while (hs_cnt < base + 2 && t < 100) begin
            @(posedge clk);
            #2;
            t++;
        end
        check("reached_beat3", hs_cnt, base + 2);
        rst_n = 1'b0;
        #1;
        check("abort_tvalid", tvalid, 0);
        check("abort_ack", ack, 0);
        check("abort_busy", busy, 0);
        exp_q.delete();
        exp_raddr.delete();
        expect_pkt(8, 64, 8'hFF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_acks(exp_ack, 200);

        p.pid  = 9;
        p.size = 6;
        b.data = word_at(9, 0, 4);
        b.keep = 8'h0F;
        b.last = 1'b0;
        exp32_q.push_back(b);
        b.data = word_at(9, 4, 4);
        b.keep = 8'h03;
        b.last = 1'b1;
        exp32_q.push_back(b);
        exp_raddr32.push_back(0);
        exp_raddr32.push_back(4);
        pkt32_q.push_back(p);
        t = 0;
        while (n_ack32 < 1 && t < 100) begin
            @(posedge clk);
            t++;
        end
        repeat (4) @(posedge clk);
        check("ack32_count", n_ack32, 1);
        check("beats32_left", exp32_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
